// File: rtl/intr_controller.sv
// Two-source interrupt controller (keyboard byte, one-shot compare timer) feeding one CPU request.
// Requests are sequenced IDLE -> REQ -> SERVICE by the CPU's take and IACK pulses.
module intr_controller #(
   parameter int TIMER_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ien,
   input  logic               idis,
   input  logic               iack,
   input  logic               irq_take,
   input  logic               kbd_valid,
   input  logic [7:0]         kbd_data,
   input  logic               cmp_we,
   input  logic [TIMER_W-1:0] cmp_wdata,
   output logic               irq,
   output logic [1:0]         irq_cause,
   output logic [7:0]         irq_data,
   output logic               kbd_overrun
);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_KBD  = 2'b01;
   localparam logic [1:0] CAUSE_TMR  = 2'b10;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t               r_state;
   logic                 r_irq;
   logic [1:0]           r_irq_cause;
   logic [7:0]           r_irq_data;
   logic                 r_kbd_overrun;
   logic                 r_enable;
   logic                 r_kbd_pend;
   logic                 r_tmr_pend;
   logic [TIMER_W-1:0]   r_timer;
   logic [TIMER_W-1:0]   r_cmp;
   logic                 r_armed;

   logic                 w_ack_kbd;
   logic                 w_ack_tmr;
   logic                 w_match;

   assign w_ack_kbd = (r_state == SERVICE) && iack && (r_irq_cause == CAUSE_KBD);
   assign w_ack_tmr = (r_state == SERVICE) && iack && (r_irq_cause == CAUSE_TMR);
   assign w_match   = r_armed && (r_timer == r_cmp);

   assign irq         = r_irq;
   assign irq_cause   = r_irq_cause;
   assign irq_data    = r_irq_data;
   assign kbd_overrun = r_kbd_overrun;

   // Enable, pending bits, keyboard byte latch and compare timer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enable      <= 1'b0;
         r_kbd_pend    <= 1'b0;
         r_tmr_pend    <= 1'b0;
         r_irq_data    <= 8'h00;
         r_kbd_overrun <= 1'b0;
         r_timer       <= '0;
         r_cmp         <= '1;
         r_armed       <= 1'b0;
      end else begin
         if (idis)
            r_enable <= 1'b0;
         else if (ien)
            r_enable <= 1'b1;

         if (w_ack_kbd) begin
            r_kbd_pend    <= 1'b0;
            r_kbd_overrun <= 1'b0;
         end
         // A byte arriving on the acknowledge cycle re-arms pending without an overrun.
         if (kbd_valid) begin
            if (!r_kbd_pend || w_ack_kbd) begin
               r_kbd_pend <= 1'b1;
               r_irq_data <= kbd_data;
            end else begin
               r_kbd_overrun <= 1'b1;
            end
         end

         r_timer <= r_timer + TIMER_W'(1);
         if (w_ack_tmr)
            r_tmr_pend <= 1'b0;
         // A compare write on the match cycle re-arms instead of firing.
         if (cmp_we) begin
            r_cmp   <= cmp_wdata;
            r_armed <= 1'b1;
         end else if (w_match) begin
            r_armed    <= 1'b0;
            r_tmr_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_irq       <= 1'b0;
         r_irq_cause <= CAUSE_NONE;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_enable && (r_kbd_pend || r_tmr_pend)) begin
                  r_state     <= REQ;
                  r_irq       <= 1'b1;
                  r_irq_cause <= r_kbd_pend ? CAUSE_KBD : CAUSE_TMR;
               end
            end
            REQ: begin
               // Once the CPU has vectored, the take is honoured even if IDIS lands alongside.
               if (irq_take) begin
                  r_state <= SERVICE;
                  r_irq   <= 1'b0;
               end else if (!r_enable) begin
                  r_state     <= IDLE;
                  r_irq       <= 1'b0;
                  r_irq_cause <= CAUSE_NONE;
               end
            end
            SERVICE: begin
               if (iack) begin
                  r_state     <= IDLE;
                  r_irq_cause <= CAUSE_NONE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_irq       <= 1'b0;
               r_irq_cause <= CAUSE_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: stimulus queues each expected irq rise (cause, byte, cycle);
// a negedge monitor pops and compares on every rising irq.
module tb_intr_controller;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ien = 1'b0, idis = 1'b0, iack = 1'b0, irq_take = 1'b0;
   logic          kbd_valid = 1'b0;
   logic [7:0]    kbd_data = 8'h00;
   logic          cmp_we = 1'b0;
   logic [TW-1:0] cmp_wdata = '0;
   logic          irq;
   logic [1:0]    irq_cause;
   logic [7:0]    irq_data;
   logic          kbd_overrun;

   always #5 clk = ~clk;

   intr_controller #(.TIMER_W(TW)) dut (
      .clk(clk), .reset(reset), .ien(ien), .idis(idis), .iack(iack), .irq_take(irq_take),
      .kbd_valid(kbd_valid), .kbd_data(kbd_data), .cmp_we(cmp_we), .cmp_wdata(cmp_wdata),
      .irq(irq), .irq_cause(irq_cause), .irq_data(irq_data), .kbd_overrun(kbd_overrun)
   );

   typedef struct {
      logic [1:0] cause;
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic       prev_irq = 1'b0;
   logic [7:0] last_kbd = 8'h00;
   int         c_match;
   int         c_match2;

   // Edge index since reset release; the DUT timer holds (cyc-1) mod 256 at edge cyc.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         prev_irq = 1'b0;
      end else begin
         if (irq && !prev_irq) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_irq: irq rose at cycle %0d cause %0h, none expected", cyc, irq_cause);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rise_cause", int'(irq_cause), int'(mon_e.cause));
               chk("rise_data", int'(irq_data), int'(mon_e.data));
               chk("rise_cycle", cyc, mon_e.at);
            end
         end
         prev_irq = irq;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic p_ien, input logic p_idis, input logic p_take, input logic p_iack);
      ien = p_ien; idis = p_idis; irq_take = p_take; iack = p_iack;
      step(1);
      ien = 1'b0; idis = 1'b0; irq_take = 1'b0; iack = 1'b0;
   endtask

   task automatic kbd(input logic [7:0] d);
      kbd_valid = 1'b1; kbd_data = d;
      step(1);
      kbd_valid = 1'b0;
   endtask

   task automatic cmp_write(input logic [TW-1:0] v);
      cmp_we = 1'b1; cmp_wdata = v;
      step(1);
      cmp_we = 1'b0;
   endtask

   task automatic push(input logic [1:0] c, input logic [7:0] d, input int at);
      exp_t e;
      e.cause = c; e.data = d; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_irq(input string name);
      int k = 0;
      while (!irq && k < 600) begin
         step(1);
         k++;
      end
      chk(name, int'(irq), 1);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_irq"}, int'(irq), 0);
      chk({tag, "_cause"}, int'(irq_cause), 0);
      chk({tag, "_data"}, int'(irq_data), 0);
      chk({tag, "_overrun"}, int'(kbd_overrun), 0);
   endtask

   function automatic int match_edge(input int v, input int after);
      int c = after + 1;
      while (((c - 1) % 256) != v) c++;
      return c;
   endfunction

   initial begin
      // Reset state
      reset = 1'b0;
      step(2);
      check_zero("reset");
      @(negedge clk) reset = 1'b1;
      step(1);

      // Basic keyboard path
      pulse(1, 0, 0, 0);
      kbd(8'h41); last_kbd = 8'h41;
      push(2'b01, 8'h41, cyc + 1);
      step(2);
      pulse(0, 0, 1, 0);
      chk("take_irq_low", int'(irq), 0);
      chk("svc_cause", int'(irq_cause), 1);
      chk("svc_data", int'(irq_data), 'h41);
      step(4);
      pulse(0, 0, 0, 1);
      chk("ack_cause", int'(irq_cause), 0);
      chk("ack_irq", int'(irq), 0);

      // Keyboard overrun
      kbd(8'h41);
      push(2'b01, 8'h41, cyc + 1);
      kbd(8'h42);
      chk("ovr_data", int'(irq_data), 'h41);
      chk("ovr_flag", int'(kbd_overrun), 1);
      wait_irq("ovr_wait");
      pulse(0, 0, 1, 0);
      chk("ovr_svc_data", int'(irq_data), 'h41);
      pulse(0, 0, 0, 1);
      chk("ovr_cleared", int'(kbd_overrun), 0);
      chk("ovr_after_data", int'(irq_data), 'h41);

      // Enable control
      pulse(0, 1, 0, 0);
      kbd(8'h55); last_kbd = 8'h55;
      step(6);
      chk("dis_no_irq", int'(irq), 0);
      pulse(1, 1, 0, 0);
      step(4);
      chk("both_no_irq", int'(irq), 0);
      pulse(1, 0, 0, 0);
      push(2'b01, 8'h55, cyc + 1);
      step(1);
      chk("en_irq_high", int'(irq), 1);
      pulse(0, 1, 0, 0);
      step(1);
      chk("idis_req_irq", int'(irq), 0);
      chk("idis_req_cause", int'(irq_cause), 0);
      pulse(1, 0, 0, 0);
      push(2'b01, 8'h55, cyc + 1);
      wait_irq("reen_wait");
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);

      // Timer one-shot
      cmp_write(8'd20);
      c_match = match_edge(20, cyc);
      push(2'b10, last_kbd, c_match + 1);
      wait_irq("tmr_wait");
      chk("tmr_cause", int'(irq_cause), 2);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      step(300);
      chk("tmr_no_refire", int'(irq), 0);

      // Compare write on the match cycle: no pending, stays armed for the next wrap
      cmp_write(8'd30);
      c_match = match_edge(30, cyc);
      wait_until(c_match - 1);
      cmp_write(8'd30);
      c_match2 = match_edge(30, c_match);
      push(2'b10, last_kbd, c_match2 + 1);
      wait_irq("rearm_wait");
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);

      // Priority and back-to-back
      cmp_write(8'd100);
      c_match = match_edge(100, cyc);
      wait_until(c_match - 1);
      kbd(8'h77); last_kbd = 8'h77;
      push(2'b01, 8'h77, c_match + 1);
      wait_irq("prio_kbd_wait");
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      push(2'b10, 8'h77, cyc + 1);
      wait_irq("prio_tmr_wait");
      chk("prio_tmr_cause", int'(irq_cause), 2);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);

      // Reset mid-SERVICE
      kbd(8'h99);
      push(2'b01, 8'h99, cyc + 1);
      kbd(8'h9A);
      wait_irq("rst_wait");
      pulse(0, 0, 1, 0);
      chk("rst_pre_cause", int'(irq_cause), 1);
      #2 reset = 1'b0;
      #1 check_zero("rst_mid");
      @(negedge clk) reset = 1'b1;
      step(20);
      chk("rst_quiet", int'(irq), 0);
      pulse(1, 0, 0, 0);
      step(10);
      chk("rst_quiet_en", int'(irq), 0);
      kbd(8'h12);
      push(2'b01, 8'h12, cyc + 1);
      wait_irq("post_rst_wait");
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);

      step(5);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_controller.md
# intr_controller

Interrupt controller for the CPU on `mother_board`. Collects two interrupt sources, the keyboard (UART receive byte complete) and an internal compare timer, and raises a single request to the CPU. It sequences each request through request, take and acknowledge, driven by the CPU's IEN/IDIS/IACK instructions and its interrupt-entry pulse. Sits between the UART receiver, the CPU execute stage and the CPU's interrupt-vector logic.

## Interface
- `TIMER_W`, default 32: width of the free-running timer and the compare register.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ien`  in  1  one-cycle pulse, IEN executed; sets global enable.
- `idis`  in  1  one-cycle pulse, IDIS executed; clears global enable.
- `iack`  in  1  one-cycle pulse, IACK executed; ends service of the current interrupt.
- `irq_take`  in  1  one-cycle pulse, CPU has vectored to the handler.
- `kbd_valid`  in  1  one-cycle pulse, UART byte received.
- `kbd_data`  in  8  received byte, valid with `kbd_valid`.
- `cmp_we`  in  1  write strobe for the timer compare register.
- `cmp_wdata`  in  TIMER_W  new compare value.
- `irq`  out  1  interrupt request to the CPU.
- `irq_cause`  out  2  cause: 2'b01 keyboard, 2'b10 timer, 2'b00 none.
- `irq_data`  out  8  latched keyboard byte.
- `kbd_overrun`  out  1  sticky flag: keyboard byte lost.

## Operation
- Reset values: `irq`=0, `irq_cause`=0, `irq_data`=0, `kbd_overrun`=0, enable=0, both pending bits=0, timer=0, compare=all-ones, armed=0, state IDLE.
- Enable: `ien` sets it and `idis` clears it. If both pulse in the same cycle, `idis` wins.
- Keyboard pending:
  - `kbd_valid` with the pending bit clear sets pending and latches `kbd_data` into `irq_data`.
  - `kbd_valid` with the pending bit already set keeps the old byte and sets `kbd_overrun`.
- Timer:
  - Counts up by 1 every cycle and wraps modulo 2^TIMER_W.
  - When timer equals compare and armed=1, the timer pending bit is set and armed is cleared (one-shot).
  - `cmp_we` loads compare and sets armed=1. If a match and a write occur in the same cycle, the write wins: no pending is set and armed stays 1.
- Priority: keyboard over timer, fixed.
- FSM:
  - IDLE: if enable and any pending bit is set, go to REQ and latch `irq_cause` from the highest-priority pending bit.
  - REQ: `irq`=1. `irq_take` moves to SERVICE. Enable cleared while in REQ returns to IDLE with `irq_cause`=0; pending bits are kept.
  - SERVICE: `irq`=0 and `irq_cause` is held. `iack` clears the pending bit named by `irq_cause`, clears `kbd_overrun` when the cause is keyboard, sets `irq_cause`=0 and returns to IDLE.
- Ignored inputs: `iack` outside SERVICE and `irq_take` outside REQ.
- New events during REQ or SERVICE still set pending bits. They are requested only after a return to IDLE.
- A keyboard event in the same cycle as an `iack` that clears keyboard pending: pending is cleared, then set again with the new byte. No overrun is flagged.

## Timing
- Event to `irq`: 2 cycles. The event is sampled at edge N, pending is visible after N, and `irq` is high after edge N+1.
- `irq_take` sampled at edge M: `irq` is low after M.
- `iack` sampled at edge K: state is IDLE after K. If another bit is pending, `irq` rises again after K+1, so there is a minimum of one IDLE cycle.
- Reset assertion at any time forces all reset values immediately, including mid-REQ and mid-SERVICE.
- `irq_data` changes only on a keyboard latch; it is stable throughout REQ and SERVICE of a keyboard cause.

## Test plan
- Basic keyboard path:
  - Stimulus: `ien`, then `kbd_valid` with 8'h41, then `irq_take` 3 cycles later, then `iack` 5 cycles later.
  - Response: `irq` rises 2 cycles after `kbd_valid`; `irq_cause`=01 and `irq_data`=8'h41; `irq` falls after `irq_take`; `irq_cause` returns to 00 after `iack`.
- Keyboard overrun:
  - Stimulus: `kbd_valid` with 8'h41, then 8'h42 before `iack`.
  - Response: `irq_data` stays 8'h41 and `kbd_overrun`=1; after `iack`, `kbd_overrun`=0.
- Timer one-shot:
  - Stimulus: TIMER_W=8, `cmp_we` with 8'd20, enable set.
  - Response: exactly one timer `irq` per wrap (256 cycles) is not expected; timer `irq` (`irq_cause`=10) occurs once and never re-fires until `cmp_we` is written again. Also check a write on the match cycle produces no pending.
- Priority and back-to-back:
  - Stimulus: timer match and `kbd_valid` in the same cycle.
  - Response: keyboard is served first. After its `iack`, one IDLE cycle follows, then `irq` with `irq_cause`=10.
- Enable control:
  - Stimulus: pending event while disabled; `ien`+`idis` together; `idis` during REQ.
  - Response: no `irq` while disabled; enable stays 0 when both pulse together; `idis` in REQ drops `irq` and keeps pending, and a later `ien` re-requests 2 cycles after.
- Reset mid-SERVICE:
  - Stimulus: drive `reset` low in SERVICE.
  - Response: all outputs go to 0 immediately, and no `irq` appears after release until a new event arrives.
